// File: rtl/spatial_filter_pkg.sv
// +----------------------------------------------------------------------+
// | spatial_filter_pkg : shared constants and types for the line buffers |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package spatial_filter_pkg;

    localparam int NUM_LINES     = 4;
    localparam int WINDOW_PIXELS = 9;

    typedef logic [1:0] line_sel_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    // Buffer index arithmetic wraps naturally because NUM_LINES is 4.
    function automatic line_sel_t sel_offset(input line_sel_t base, input int unsigned off);
        return base + line_sel_t'(off);
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_buffer_ctrl_if.sv
// +----------------------------------------------------------------------+
// | line_buffer_ctrl_if : pixel input and 3x3 window output bundle       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface line_buffer_ctrl_if
    import spatial_filter_pkg::*;
#(
    parameter int PIXEL_SIZE = 32
) ();

    logic [PIXEL_SIZE-1:0]               i_pixel_data;
    logic                                i_pixel_valid;
    logic                                o_full;
    logic [WINDOW_PIXELS*PIXEL_SIZE-1:0] o_window;
    logic                                o_window_valid;
    logic                                o_intr;

    modport master (
        output i_pixel_data,
        output i_pixel_valid,
        input  o_full,
        input  o_window,
        input  o_window_valid,
        input  o_intr
    );

    modport slave (
        input  i_pixel_data,
        input  i_pixel_valid,
        output o_full,
        output o_window,
        output o_window_valid,
        output o_intr
    );

endinterface

`default_nettype wire

// File: rtl/line_buffer_ctrl_line_buffer.sv
// +----------------------------------------------------------------------+
// | line_buffer : one image line of storage, three-column read port      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module line_buffer #(
    parameter int PIXEL_SIZE  = 32,
    parameter int IMAGE_WIDTH = 512
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic [PIXEL_SIZE-1:0]   i_data,
    input  wire logic                    i_data_valid,
    input  wire logic                    i_data_rd,
    output logic      [3*PIXEL_SIZE-1:0] o_data
);

    localparam int PTR_W = $clog2(IMAGE_WIDTH);

    logic [PIXEL_SIZE-1:0] mem_q [IMAGE_WIDTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;

    always_ff @(posedge clk) begin
        if (i_data_valid) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (i_data_valid) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (i_data_rd)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Columns past the line end wrap to the start; the controller flags those windows invalid.
    assign o_data = {mem_q[rd_ptr_q], mem_q[rd_ptr_q + PTR_W'(1)], mem_q[rd_ptr_q + PTR_W'(2)]};

endmodule

`default_nettype wire

// File: rtl/line_buffer_ctrl.sv
// +----------------------------------------------------------------------+
// | line_buffer_ctrl : routes pixels into 4 line buffers, emits 3x3 rows |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module line_buffer_ctrl
    import spatial_filter_pkg::*;
#(
    parameter int PIXEL_SIZE  = 32,
    parameter int IMAGE_WIDTH = 512
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    line_buffer_ctrl_if.slave bus
);

    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int CNT_W = $clog2(NUM_LINES*IMAGE_WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_full_lvl  = CNT_W'(NUM_LINES*IMAGE_WIDTH);
    localparam logic [CNT_W-1:0] c_read_lvl  = CNT_W'(3*IMAGE_WIDTH);
    localparam logic [COL_W-1:0] c_last_col  = COL_W'(IMAGE_WIDTH-1);
    localparam logic [COL_W-1:0] c_last_win  = COL_W'(IMAGE_WIDTH-3);

    line_sel_t        wr_sel_q, wr_sel_d;
    line_sel_t        rd_sel_q, rd_sel_d;
    logic [COL_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [COL_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [0:0]       state_q, state_d;
    logic             intr_q, intr_d;

    logic w_full;
    logic w_wr_accept;
    logic w_rd_strobe;
    logic w_window_valid;
    logic [3*PIXEL_SIZE-1:0] w_lb_rows [NUM_LINES];

    assign w_full         = (pix_cnt_q == c_full_lvl);
    assign w_wr_accept    = bus.i_pixel_valid && !w_full;
    assign w_rd_strobe    = (state_q == ST_READ);
    assign w_window_valid = w_rd_strobe && (rd_cnt_q <= c_last_win);

    generate
        for (genvar i = 0; i < NUM_LINES; i++) begin : g_lines
            localparam line_sel_t c_idx = line_sel_t'(i);
            logic w_wr_en;
            logic w_rd_en;

            assign w_wr_en = w_wr_accept && (wr_sel_q == c_idx);
            // Read the three oldest lines: every buffer except the one just behind rd_sel.
            assign w_rd_en = w_rd_strobe && ((c_idx - rd_sel_q) != 2'd3);

            line_buffer #(
                .PIXEL_SIZE  (PIXEL_SIZE),
                .IMAGE_WIDTH (IMAGE_WIDTH)
            ) u_line_buffer (
                .clk          (clk),
                .rst_n        (reset_n),
                .i_data       (bus.i_pixel_data),
                .i_data_valid (w_wr_en),
                .i_data_rd    (w_rd_en),
                .o_data       (w_lb_rows[i])
            );
        end
    endgenerate

    always_comb begin
        wr_sel_d  = wr_sel_q;
        wr_cnt_d  = wr_cnt_q;
        rd_sel_d  = rd_sel_q;
        rd_cnt_d  = rd_cnt_q;
        pix_cnt_d = pix_cnt_q;
        state_d   = state_q;
        intr_d    = 1'b0;

        if (w_wr_accept) begin
            if (wr_cnt_q == c_last_col) begin
                wr_cnt_d = '0;
                wr_sel_d = sel_offset(wr_sel_q, 1);
            end else begin
                wr_cnt_d = wr_cnt_q + COL_W'(1);
            end
        end

        case ({w_wr_accept, w_rd_strobe})
            2'b10:   pix_cnt_d = pix_cnt_q + CNT_W'(1);
            2'b01:   pix_cnt_d = pix_cnt_q - CNT_W'(1);
            default: pix_cnt_d = pix_cnt_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (pix_cnt_q >= c_read_lvl) state_d = ST_READ;
            end
            ST_READ: begin
                if (rd_cnt_q == c_last_col) begin
                    rd_cnt_d = '0;
                    rd_sel_d = sel_offset(rd_sel_q, 1);
                    intr_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + COL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_sel_q  <= '0;
            wr_cnt_q  <= '0;
            rd_sel_q  <= '0;
            rd_cnt_q  <= '0;
            pix_cnt_q <= '0;
            state_q   <= ST_IDLE;
            intr_q    <= 1'b0;
        end else begin
            wr_sel_q  <= wr_sel_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_sel_q  <= rd_sel_d;
            rd_cnt_q  <= rd_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            state_q   <= state_d;
            intr_q    <= intr_d;
        end
    end

    assign bus.o_full         = w_full;
    assign bus.o_window_valid = w_window_valid;
    assign bus.o_intr         = intr_q;
    assign bus.o_window       = w_window_valid ?
                                {w_lb_rows[sel_offset(rd_sel_q, 0)],
                                 w_lb_rows[sel_offset(rd_sel_q, 1)],
                                 w_lb_rows[sel_offset(rd_sel_q, 2)]} : '0;

endmodule

`default_nettype wire
